// File: rtl/mvm_accum.sv
// Row accumulator for DPE partial dot products, with a fall-through output FIFO.
// Completed rows queue in the FIFO; a registered stall throttles upstream before it fills.
module mvm_accum #(
  parameter int OPREC        = 32,
  parameter int CNTW         = 8,
  parameter int ACCW         = OPREC + CNTW,
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cfg_valid,
  input  logic [CNTW-1:0]        i_cfg_chunks,
  input  logic                   i_valid,
  input  logic [OPREC-1:0]       i_result,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [ACCW-1:0]        o_data,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCCW = PTRW + 1;
  localparam logic [OCCW-1:0] OCC_FULL = OCCW'(FIFO_DEPTH);
  localparam logic [OCCW-1:0] STALL_TH = OCCW'(FIFO_DEPTH - STALL_MARGIN);

  logic [CNTW-1:0] chunks_reg;
  logic [CNTW-1:0] count;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] sum;
  logic [ACCW-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [OCCW-1:0] occ;
  logic [OCCW-1:0] occ_next;

  logic cfg_accept;
  logic last;
  logic push;
  logic pop;
  logic full;
  logic wr_en;

  assign cfg_accept = i_cfg_valid && (count == '0) && !i_valid;
  assign last       = (count == chunks_reg - CNTW'(1));
  assign sum        = acc + ACCW'($signed(i_result));
  assign push       = i_valid && last;
  assign full       = (occ == OCC_FULL);
  assign o_valid    = (occ != '0);
  assign pop        = o_valid && i_ready;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en      = push && (!full || pop);
  assign occ_next   = occ + OCCW'(wr_en) - OCCW'(pop);
  assign o_busy     = (count != '0);
  assign o_data     = o_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chunks_reg <= CNTW'(1);
      count      <= '0;
      acc        <= '0;
    end else begin
      if (cfg_accept)
        chunks_reg <= (i_cfg_chunks == '0) ? CNTW'(1) : i_cfg_chunks;
      if (i_valid) begin
        if (last) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum;
          count <= count + CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      o_stall    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTRW'(1);
      occ     <= occ_next;
      o_stall <= (occ_next >= STALL_TH);
      if (push && full && !pop)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= sum;
  end

endmodule

// File: tb/tb_mvm_accum.sv
// Directed bench for mvm_accum: row sums, sign extension, FIFO full/overflow,
// config gating and asynchronous reset mid-row.
module tb_mvm_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cfg_valid;
  logic [7:0]  i_cfg_chunks;
  logic        i_valid;
  logic [31:0] i_result;
  logic        o_stall;
  logic        o_valid;
  logic [39:0] o_data;
  logic        i_ready;
  logic        o_busy;
  logic        o_overflow;

  int checks = 0;
  int errors = 0;

  mvm_accum dut (
    .clk          (clk),
    .rst          (rst),
    .i_cfg_valid  (i_cfg_valid),
    .i_cfg_chunks (i_cfg_chunks),
    .i_valid      (i_valid),
    .i_result     (i_result),
    .o_stall      (o_stall),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] val);
    i_valid  = 1'b1;
    i_result = val;
    tick();
    i_valid  = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] n);
    i_cfg_valid  = 1'b1;
    i_cfg_chunks = n;
    tick();
    i_cfg_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_cfg_valid = 1'b0; i_cfg_chunks = '0;
    i_valid = 1'b0; i_result = '0; i_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_data", o_data, 0);
    rst = 1'b1;
    i_ready = 1'b1;

    // four chunks of 64
    cfg(8'd4);
    i_valid = 1'b1; i_result = 32'd64;
    tick();
    chk("r4_busy1", o_busy, 1);
    chk("r4_nov1", o_valid, 0);
    tick();
    chk("r4_busy2", o_busy, 1);
    tick();
    chk("r4_busy3", o_busy, 1);
    chk("r4_nov3", o_valid, 0);
    tick();
    i_valid = 1'b0;
    chk("r4_valid", o_valid, 1);
    chk("r4_data", o_data, 40'd256);
    chk("r4_idle", o_busy, 0);
    tick();
    chk("r4_pulse", o_valid, 0);

    // sign extension
    cfg(8'd2);
    send(32'd100);
    send(-32'sd300);
    chk("neg_valid", o_valid, 1);
    chk("neg_data", o_data, 40'hFF_FFFF_FF38);
    tick();
    chk("neg_pop", o_valid, 0);

    // overflow with downstream stalled
    cfg(8'd1);
    i_ready = 1'b0;
    send(32'd1);
    chk("ov_stall1", o_stall, 0);
    chk("ov_head", o_data, 40'd1);
    send(32'd2);
    chk("ov_stall2", o_stall, 1);
    send(32'd3);
    send(32'd4);
    chk("ov_ovf4", o_overflow, 0);
    send(32'd5);
    chk("ov_ovf5", o_overflow, 1);
    send(32'd6);
    chk("ov_busy", o_busy, 0);
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ov_pop_valid", o_valid, 1);
      chk("ov_pop_data", o_data, 40'(k));
      tick();
    end
    chk("ov_empty", o_valid, 0);
    chk("ov_sticky", o_overflow, 1);
    chk("ov_unstall", o_stall, 0);

    // full FIFO with simultaneous push and pop
    i_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_ovf", o_overflow, 0);
    rst = 1'b1;
    send(32'd10);
    send(32'd20);
    send(32'd30);
    send(32'd40);
    chk("fp_full_stall", o_stall, 1);
    i_ready = 1'b1;
    send(32'd50);
    chk("fp_ovf", o_overflow, 0);
    chk("fp_stall", o_stall, 1);
    for (int k = 2; k <= 5; k++) begin
      chk("fp_valid", o_valid, 1);
      chk("fp_data", o_data, 40'(k * 10));
      tick();
    end
    chk("fp_empty", o_valid, 0);
    chk("fp_ovf_end", o_overflow, 0);

    // config only accepted when idle
    cfg(8'd3);
    send(32'd5);
    send(32'd6);
    cfg(8'd5);
    send(32'd7);
    chk("cfg_ign_valid", o_valid, 1);
    chk("cfg_ign_data", o_data, 40'd18);
    chk("cfg_ign_busy", o_busy, 0);
    tick();
    cfg(8'd0);
    send(32'd9);
    chk("cfg0_valid", o_valid, 1);
    chk("cfg0_data", o_data, 40'd9);
    tick();
    i_cfg_valid = 1'b1; i_cfg_chunks = 8'd2;
    send(32'd11);
    i_cfg_valid = 1'b0;
    chk("cfg_iv_data", o_data, 40'd11);
    tick();
    send(32'd12);
    chk("cfg_iv_next", o_data, 40'd12);
    chk("cfg_iv_busy", o_busy, 0);
    tick();

    // asynchronous reset mid-row
    cfg(8'd4);
    send(32'd1);
    send(32'd2);
    chk("ar_busy", o_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy_now", o_busy, 0);
    i_valid = 1'b1; i_result = 32'd99;
    tick();
    chk("ar_ign_valid", o_valid, 0);
    chk("ar_ign_busy", o_busy, 0);
    i_valid = 1'b0;
    rst = 1'b1;
    cfg(8'd2);
    send(32'd3);
    send(32'd4);
    chk("ar_new_valid", o_valid, 1);
    chk("ar_new_data", o_data, 40'd7);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_accum.md
MVM_ACCUM -- requirements
Module: mvm_accum

Interface
REQ-001 SHALL have parameter OPREC, default 32, the width of each signed partial dot product from the DPE.
REQ-002 SHALL have parameter CNTW, default 8, the width of the chunk-count config and counter.
REQ-003 SHALL have parameter ACCW, default OPREC+CNTW (40), the accumulator and output width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2, the output FIFO entries.
REQ-005 SHALL have parameter STALL_MARGIN, default 2, the free entries reserved for in-flight DPE results.
REQ-006 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have i_cfg_valid, input, 1: config strobe.
REQ-009 SHALL have i_cfg_chunks, input, CNTW: partial results per output row.
REQ-010 SHALL have i_valid, input, 1: a DPE partial result is present.
REQ-011 SHALL have i_result, input, OPREC: signed DPE partial result.
REQ-012 SHALL have o_stall, output, 1: upstream must stop issuing DPE inputs.
REQ-013 SHALL have o_valid, output, 1: the FIFO head is valid.
REQ-014 SHALL have o_data, output, ACCW: signed row sum at the FIFO head.
REQ-015 SHALL have i_ready, input, 1: downstream accepts the FIFO head.
REQ-016 SHALL have o_busy, output, 1: a row is partially accumulated (count != 0).
REQ-017 SHALL have o_overflow, output, 1: sticky flag, a completed row was dropped.

Function
REQ-018 SHALL hold chunks_reg (reset 1); i_cfg_chunks value 0 SHALL load as 1.
REQ-019 SHALL accept config only when count == 0 and i_valid == 0 in the same cycle; otherwise it is ignored with no state change.
REQ-020 SHALL sign-extend i_result to ACCW; the add SHALL wrap modulo 2^ACCW with no saturation.
REQ-021 On i_valid when count < chunks_reg-1: acc <= acc + ext(i_result) and count <= count+1.
REQ-022 On i_valid when count == chunks_reg-1: push acc + ext(i_result) to the FIFO, then acc <= 0 and count <= 0.
REQ-023 With chunks_reg == 1, every i_valid SHALL push ext(i_result) directly.
REQ-024 Latency: the final partial in cycle T SHALL appear on o_data with o_valid=1 in cycle T+1 if the FIFO was empty (first-word fall-through).
REQ-025 A pop SHALL occur when o_valid && i_ready; the head advances the next cycle.
REQ-026 On simultaneous push and pop when full, both SHALL succeed and occupancy SHALL be unchanged.
REQ-027 On a push when full with no pop, the row SHALL be dropped, o_overflow set (sticky until reset), and acc/count still cleared.
REQ-028 o_stall SHALL be registered: 1 when next occupancy >= FIFO_DEPTH-STALL_MARGIN, else 0.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-030 o_data SHALL be don't-care when o_valid == 0; o_valid SHALL never depend combinationally on i_ready.
REQ-031 i_ready SHALL NOT affect accumulation; only o_stall throttles upstream.

Reset
REQ-032 Asserting rst low SHALL immediately clear acc, count, the FIFO pointers and occupancy, and o_overflow, and set chunks_reg to 1.
REQ-033 During reset, outputs SHALL be o_valid=0, o_stall=0, o_busy=0, o_overflow=0, o_data=0.
REQ-034 Reset asserted mid-row SHALL discard the partial sum; i_valid SHALL be ignored while rst is low.
REQ-035 Deassertion of rst is assumed synchronous to clk; the first accepted input is on the first rising edge with rst high.

Verification
REQ-036 Reset, then cfg chunks=4, then four i_valid results of 64 with i_ready=1 -> a single o_valid pulse with o_data=256 one cycle after the 4th result; o_busy high during results 2-4.
REQ-037 cfg chunks=2, results 100 then -300 -> o_data = -200 (ACCW sign-extended 0xFFFFFFFF38).
REQ-038 cfg chunks=1, i_ready=0, six results 1..6 -> o_stall high after 2 pushes; first 4 rows stored; o_overflow=1; pop then yields 1,2,3,4 in order.
REQ-039 FIFO full, i_ready=1, and push in the same cycle -> occupancy stays 4, o_overflow stays 0, and order is preserved.
REQ-040 cfg chunks=3, two results, cfg chunks=5 attempted, third result -> config ignored and row completes at 3; chunks=0 then loads as 1.
REQ-041 Mid-row (count=2), pulse rst low asynchronously between edges -> o_busy=0 immediately; the next row sums from 0.
